// File: rtl/cp_pkg.sv
// Shared coprocessor dispatch definitions: opcodes, op selects and controller states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cp_pkg;

    localparam logic [6:0] OP_CUSTOM0    = 7'b0001011;
    localparam logic [6:0] OP_LEGACY_GCD = 7'b0000000;
    localparam logic [6:0] OP_LEGACY_LCM = 7'b1111111;

    localparam int unsigned CP_GCD = 0;
    localparam int unsigned CP_LCM = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } cp_state_e;

endpackage

// File: rtl/cp_op_decode.sv
// Recognises coprocessor instructions in Decode and maps them to an op select.
// Latency: purely combinational.
// Backpressure: none; outputs follow op/funct3 directly.
module cp_op_decode
    import cp_pkg::*;
#(
    parameter int NUM_OPS    = 4,
    parameter int OPSEL_W    = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1,
    parameter int LEGACY_OPS = 1
) (
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    output logic               is_cp,
    output logic               illegal_cp,
    output logic [OPSEL_W-1:0] opsel
);

    always_comb begin
        is_cp      = 1'b0;
        illegal_cp = 1'b0;
        opsel      = '0;
        if (op == OP_CUSTOM0) begin
            if (int'(funct3) < NUM_OPS) begin
                is_cp = 1'b1;
                opsel = OPSEL_W'(funct3);
            end else begin
                illegal_cp = 1'b1;
            end
        end else if ((LEGACY_OPS != 0) && (op == OP_LEGACY_GCD)) begin
            is_cp = 1'b1;
            opsel = OPSEL_W'(CP_GCD);
        end else if ((LEGACY_OPS != 0) && (op == OP_LEGACY_LCM)) begin
            is_cp = 1'b1;
            opsel = OPSEL_W'(CP_LCM);
        end
    end

endmodule

// File: rtl/cp_dispatch_ctrl.sv
// Dispatches one coprocessor op at a time from Decode and writes its result back to rd.
// Latency: min 3 stall cycles (IDLE->ISSUE->WAIT->WB); WAIT bounded by TIMEOUT when non-zero.
// Backpressure: request held stable until cp_req_ready; responses are always accepted in WAIT.
module cp_dispatch_ctrl
    import cp_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_OPS    = 4,
    parameter int OPSEL_W    = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1,
    parameter int TIMEOUT    = 255,
    parameter int LEGACY_OPS = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               dec_valid,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic [4:0]         rd,
    input  logic [XLEN-1:0]    rs1_val,
    input  logic [XLEN-1:0]    rs2_val,
    input  logic               flush,
    output logic               is_cp,
    output logic               illegal_cp,
    output logic               stall_d,
    output logic               cp_req_valid,
    input  logic               cp_req_ready,
    output logic [OPSEL_W-1:0] cp_opsel,
    output logic [XLEN-1:0]    cp_a,
    output logic [XLEN-1:0]    cp_b,
    input  logic               cp_resp_valid,
    input  logic [XLEN-1:0]    cp_resp_data,
    output logic               wb_valid,
    output logic [4:0]         wb_rd,
    output logic [XLEN-1:0]    wb_data,
    output logic               err_timeout
);

    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT != 0);

    typedef struct packed {
        logic [OPSEL_W-1:0] opsel;
        logic [4:0]         rd;
        logic [XLEN-1:0]    a;
        logic [XLEN-1:0]    b;
    } cp_cmd_t;

    cp_state_e          state_q, state_d;
    cp_cmd_t            cmd_q;
    logic [CNT_W-1:0]   cnt_q, cnt_inc;
    logic               err_q;
    logic [XLEN-1:0]    wb_data_q;
    logic [OPSEL_W-1:0] dec_opsel;
    logic               capture, handshake, resp_take, tmo_hit;

    cp_op_decode #(
        .NUM_OPS    (NUM_OPS),
        .OPSEL_W    (OPSEL_W),
        .LEGACY_OPS (LEGACY_OPS)
    ) u_dec (
        .op         (op),
        .funct3     (funct3),
        .is_cp      (is_cp),
        .illegal_cp (illegal_cp),
        .opsel      (dec_opsel)
    );

    // Saturating so a disabled timeout can sit in WAIT indefinitely without wrapping.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        stall_d      = 1'b0;
        cp_req_valid = 1'b0;
        wb_valid     = 1'b0;
        capture      = 1'b0;
        handshake    = 1'b0;
        resp_take    = 1'b0;
        tmo_hit      = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall_d = is_cp & dec_valid;
                if (dec_valid && is_cp && !flush) begin
                    capture = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cp_req_valid = 1'b1;
                stall_d      = 1'b1;
                // An accepted request is committed even if a flush arrives alongside it.
                if (cp_req_ready) begin
                    handshake = 1'b1;
                    state_d   = WAIT;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                stall_d = 1'b1;
                if (cp_resp_valid) begin
                    resp_take = 1'b1;
                    state_d   = WB;
                end else if (TMO_EN && (cnt_inc == CNT_W'(TIMEOUT))) begin
                    tmo_hit = 1'b1;
                    state_d = WB;
                end
            end
            WB: begin
                wb_valid = (cmd_q.rd != 5'd0);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            wb_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                cmd_q <= '{opsel: dec_opsel, rd: rd, a: rs1_val, b: rs2_val};
            end
            if (handshake) begin
                cnt_q <= '0;
                err_q <= 1'b0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_inc;
            end
            if (resp_take) begin
                wb_data_q <= cp_resp_data;
            end else if (tmo_hit) begin
                wb_data_q <= '0;
                err_q     <= 1'b1;
            end
        end
    end

    assign cp_opsel    = cmd_q.opsel;
    assign cp_a        = cmd_q.a;
    assign cp_b        = cmd_q.b;
    assign wb_rd       = cmd_q.rd;
    assign wb_data     = wb_data_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_cp_dispatch_ctrl.sv
// Randomised and directed bench for cp_dispatch_ctrl against a transaction-level model.
module tb_cp_dispatch_ctrl;

    localparam int T = 8;
    localparam logic [6:0] C0  = 7'b0001011;
    localparam logic [6:0] LG  = 7'b0000000;
    localparam logic [6:0] LL  = 7'b1111111;
    localparam logic [6:0] NOP = 7'b0010011;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dec_valid, flush, cp_req_ready, cp_resp_valid;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] rs1_val, rs2_val, cp_resp_data;
    logic        is_cp, illegal_cp, stall_d, cp_req_valid, wb_valid, err_timeout;
    logic [1:0]  cp_opsel;
    logic [31:0] cp_a, cp_b, wb_data;
    logic [4:0]  wb_rd;

    int   n_chk  = 0;
    int   n_fail = 0;
    logic err_m  = 1'b0;

    typedef struct {
        logic legal; logic illegal; logic [1:0] opsel;
        int stall; int req; int wb; int req_first; int wb_at; int cycles;
        logic [31:0] data; logic [4:0] wrd; logic err;
    } exp_t;

    typedef struct {
        logic is_cp; logic illegal; logic [1:0] opsel;
        int stall; int req; int wb; int req_first; int wb_at; int changes;
        logic [31:0] data; logic [4:0] wrd; logic err; logic [31:0] a; logic [31:0] b;
    } obs_t;

    cp_dispatch_ctrl #(.TIMEOUT(T)) dut (
        .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid), .op(op), .funct3(funct3),
        .rd(rd), .rs1_val(rs1_val), .rs2_val(rs2_val), .flush(flush),
        .is_cp(is_cp), .illegal_cp(illegal_cp), .stall_d(stall_d),
        .cp_req_valid(cp_req_valid), .cp_req_ready(cp_req_ready), .cp_opsel(cp_opsel),
        .cp_a(cp_a), .cp_b(cp_b), .cp_resp_valid(cp_resp_valid), .cp_resp_data(cp_resp_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Transaction model: d = ISSUE cycles with ready low, r = WAIT cycles before the response,
    // fi = ISSUE cycle index carrying flush (-1 none), fidle = flush on the dispatch cycle.
    function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rdv,
                                   input int d, input int r, input logic [31:0] resp,
                                   input int fi, input bit fidle, input logic err_prev);
        exp_t e;
        int   w;
        e = '{default: 0};
        e.legal   = (opc == C0 && f3 < 3'd4) || opc == LG || opc == LL;
        e.illegal = (opc == C0 && f3 >= 3'd4);
        e.opsel   = (opc == C0) ? f3[1:0] : ((opc == LL) ? 2'd1 : 2'd0);
        e.err = err_prev; e.req_first = -1; e.wb_at = -1; e.cycles = 4;
        if (!e.legal || fidle) begin
            e.stall = e.legal ? 1 : 0;
        end else if (fi >= 0 && fi < d) begin
            e.req = fi + 1; e.stall = fi + 2; e.req_first = 1; e.cycles = fi + 5;
        end else begin
            w = (r < T) ? r + 1 : T;
            e.req = d + 1; e.stall = d + 2 + w; e.req_first = 1; e.cycles = d + w + 4;
            e.wb = (rdv != 5'd0) ? 1 : 0;
            e.wb_at = (rdv != 5'd0) ? d + 2 + w : -1;
            e.data = (r < T) ? resp : 32'd0;
            e.wrd = rdv;
            e.err = (r >= T);
        end
        return e;
    endfunction

    task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rdv,
                          input logic [31:0] a, input logic [31:0] b, input int d, input int r,
                          input logic [31:0] resp, input int fi, input bit fidle, input bit fwait,
                          input int ncyc, output obs_t o);
        bit hs, hs_now;
        int req_seen, after;
        o = '{default: 0}; o.req_first = -1; o.wb_at = -1;
        hs = 0; req_seen = 0; after = 0;
        @(negedge clk);
        dec_valid = 1'b1; op = opc; funct3 = f3; rd = rdv; rs1_val = a; rs2_val = b;
        flush = fidle; cp_req_ready = 1'b0;
        cp_resp_valid = 1'($urandom_range(0, 1)); cp_resp_data = $urandom;
        #1;
        o.is_cp = is_cp; o.illegal = illegal_cp;
        if (stall_d) o.stall++;
        if (cp_req_valid) o.req++;
        if (wb_valid) o.wb++;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            dec_valid = 1'b0; op = NOP; funct3 = 3'($urandom); rd = 5'($urandom);
            rs1_val = $urandom; rs2_val = $urandom;
            cp_req_ready = !hs && (req_seen == d);
            flush = (!hs && fi >= 0 && req_seen == fi) || (fwait && hs && after == 0);
            if (hs) begin
                cp_resp_valid = (after >= r);
                cp_resp_data  = (after == r) ? resp : $urandom;
            end else begin
                cp_resp_valid = 1'($urandom_range(0, 1));
                cp_resp_data  = $urandom;
            end
            #1;
            if (stall_d) o.stall++;
            if (wb_valid) begin
                o.wb++;
                if (o.wb_at < 0) begin o.wb_at = k; o.data = wb_data; o.wrd = wb_rd; end
            end
            hs_now = 0;
            if (cp_req_valid) begin
                if (o.req_first < 0) begin
                    o.req_first = k; o.a = cp_a; o.b = cp_b; o.opsel = cp_opsel;
                end else if (cp_a !== o.a || cp_b !== o.b || cp_opsel !== o.opsel) begin
                    o.changes++;
                end
                o.req++; req_seen++; hs_now = cp_req_ready;
            end
            if (hs) after++;
            if (hs_now) hs = 1;
        end
        o.err = err_timeout;
        flush = 1'b0; cp_req_ready = 1'b0; cp_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++; if ({is_cp, illegal_cp, stall_d, cp_req_valid, wb_valid, err_timeout} !== 6'd0) begin
            n_fail++; $display("FAIL reset.flags got %b expected 000000",
                {is_cp, illegal_cp, stall_d, cp_req_valid, wb_valid, err_timeout}); end
        n_chk++; if ({cp_opsel, cp_a, cp_b} !== 66'd0) begin
            n_fail++; $display("FAIL reset.req_regs got %0h/%0h/%0h expected 0", cp_opsel, cp_a, cp_b); end
        n_chk++; if ({wb_rd, wb_data} !== 37'd0) begin
            n_fail++; $display("FAIL reset.wb_regs got %0h/%0h expected 0", wb_rd, wb_data); end
    endtask

    task automatic test_decode();
        logic [6:0] ops [5] = '{C0, LG, LL, 7'b0110011, 7'b0001010};
        exp_t e;
        dec_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int f = 0; f < 8; f++) begin
                @(negedge clk); op = ops[i]; funct3 = 3'(f); #1;
                e = model(ops[i], 3'(f), 5'd1, 0, 0, 32'd0, -1, 1'b0, 1'b0);
                n_chk++; if (is_cp !== e.legal || illegal_cp !== e.illegal) begin
                    n_fail++; $display("FAIL decode op=%b f3=%0d got is_cp=%b ill=%b expected %b %b",
                        ops[i], f, is_cp, illegal_cp, e.legal, e.illegal); end
            end
        end
        op = NOP;
    endtask

    task automatic test_basic();
        obs_t o; exp_t e;
        e = model(C0, 3'd0, 5'd5, 0, 0, 32'd6, -1, 1'b0, err_m);
        run_op(C0, 3'd0, 5'd5, 32'd48, 32'd18, 0, 0, 32'd6, -1, 1'b0, 1'b0, e.cycles, o);
        err_m = e.err;
        n_chk++; if (o.req_first !== 1 || o.wb_at !== 3) begin
            n_fail++; $display("FAIL basic.timing got req@%0d wb@%0d expected req@1 wb@3", o.req_first, o.wb_at); end
        n_chk++; if (o.data !== 32'd6 || o.wrd !== 5'd5) begin
            n_fail++; $display("FAIL basic.wb got data=%0d rd=%0d expected 6 5", o.data, o.wrd); end
        n_chk++; if (o.stall !== 3) begin
            n_fail++; $display("FAIL basic.stall got %0d cycles expected 3", o.stall); end
        n_chk++; if (o.a !== 32'd48 || o.b !== 32'd18 || o.opsel !== 2'd0) begin
            n_fail++; $display("FAIL basic.operands got %0d %0d sel %0d expected 48 18 0", o.a, o.b, o.opsel); end
    endtask

    task automatic test_legacy_backpressure();
        obs_t o; exp_t e;
        e = model(LL, 3'd6, 5'd7, 5, 1, 32'd12, -1, 1'b0, err_m);
        run_op(LL, 3'd6, 5'd7, 32'd4, 32'd6, 5, 1, 32'd12, -1, 1'b0, 1'b0, e.cycles, o);
        err_m = e.err;
        n_chk++; if (o.req !== 6 || o.changes !== 0) begin
            n_fail++; $display("FAIL legacy.hold got req=%0d changes=%0d expected 6 0", o.req, o.changes); end
        n_chk++; if (o.a !== 32'd4 || o.b !== 32'd6 || o.opsel !== 2'd1) begin
            n_fail++; $display("FAIL legacy.operands got %0d %0d sel %0d expected 4 6 1", o.a, o.b, o.opsel); end
        n_chk++; if (o.data !== 32'd12 || o.wb !== 1 || o.wb_at !== e.wb_at) begin
            n_fail++; $display("FAIL legacy.wb got data=%0d n=%0d at=%0d expected 12 1 %0d",
                o.data, o.wb, o.wb_at, e.wb_at); end
        e = model(LG, 3'd3, 5'd2, 0, 2, 32'd9, -1, 1'b0, err_m);
        run_op(LG, 3'd3, 5'd2, 32'd30, 32'd12, 0, 2, 32'd9, -1, 1'b0, 1'b0, e.cycles, o);
        err_m = e.err;
        n_chk++; if (o.opsel !== 2'd0 || o.data !== 32'd9) begin
            n_fail++; $display("FAIL legacy_gcd got sel=%0d data=%0d expected 0 9", o.opsel, o.data); end
    endtask

    task automatic test_timeout();
        obs_t o; exp_t e;
        int rs [3] = '{40, 7, 8};
        for (int i = 0; i < 3; i++) begin
            e = model(C0, 3'd1, 5'd3, 0, rs[i], 32'hCAFE, -1, 1'b0, err_m);
            run_op(C0, 3'd1, 5'd3, 32'd1, 32'd2, 0, rs[i], 32'hCAFE, -1, 1'b0, 1'b0, e.cycles, o);
            err_m = e.err;
            n_chk++; if (o.err !== e.err || o.data !== e.data || o.stall !== e.stall) begin
                n_fail++; $display("FAIL timeout r=%0d got err=%b data=%0h stall=%0d expected %b %0h %0d",
                    rs[i], o.err, o.data, o.stall, e.err, e.data, e.stall); end
            if (i == 0) begin
                e = model(C0, 3'd2, 5'd4, 1, 0, 32'd5, -1, 1'b0, err_m);
                run_op(C0, 3'd2, 5'd4, 32'd1, 32'd1, 1, 0, 32'd5, -1, 1'b0, 1'b0, e.cycles, o);
                err_m = e.err;
                n_chk++; if (o.err !== 1'b0 || o.data !== 32'd5) begin
                    n_fail++; $display("FAIL timeout.clear got err=%b data=%0d expected 0 5", o.err, o.data); end
            end
        end
    endtask

    task automatic test_flush();
        obs_t o; exp_t e;
        e = model(C0, 3'd3, 5'd8, 3, 0, 32'd77, 1, 1'b0, err_m);
        run_op(C0, 3'd3, 5'd8, 32'd5, 32'd6, 3, 0, 32'd77, 1, 1'b0, 1'b0, e.cycles, o);
        err_m = e.err;
        n_chk++; if (o.req !== 2 || o.wb !== 0 || o.stall !== 3) begin
            n_fail++; $display("FAIL flush_issue got req=%0d wb=%0d stall=%0d expected 2 0 3", o.req, o.wb, o.stall); end
        e = model(C0, 3'd3, 5'd8, 2, 1, 32'd78, 2, 1'b0, err_m);
        run_op(C0, 3'd3, 5'd8, 32'd5, 32'd6, 2, 1, 32'd78, 2, 1'b0, 1'b0, e.cycles, o);
        err_m = e.err;
        n_chk++; if (o.wb !== 1 || o.data !== 32'd78) begin
            n_fail++; $display("FAIL flush_with_ready got wb=%0d data=%0d expected 1 78", o.wb, o.data); end
        e = model(C0, 3'd0, 5'd9, 0, 3, 32'd79, -1, 1'b0, err_m);
        run_op(C0, 3'd0, 5'd9, 32'd5, 32'd6, 0, 3, 32'd79, -1, 1'b0, 1'b1, e.cycles, o);
        err_m = e.err;
        n_chk++; if (o.wb !== 1 || o.data !== 32'd79 || o.wb_at !== e.wb_at) begin
            n_fail++; $display("FAIL flush_wait got wb=%0d data=%0d at=%0d expected 1 79 %0d",
                o.wb, o.data, o.wb_at, e.wb_at); end
        e = model(C0, 3'd0, 5'd9, 0, 0, 32'd1, -1, 1'b1, err_m);
        run_op(C0, 3'd0, 5'd9, 32'd5, 32'd6, 0, 0, 32'd1, -1, 1'b1, 1'b0, e.cycles, o);
        n_chk++; if (o.req !== 0 || o.wb !== 0) begin
            n_fail++; $display("FAIL flush_idle got req=%0d wb=%0d expected 0 0", o.req, o.wb); end
    endtask

    task automatic test_illegal();
        obs_t o; exp_t e;
        e = model(C0, 3'd5, 5'd6, 0, 0, 32'd1, -1, 1'b0, err_m);
        run_op(C0, 3'd5, 5'd6, 32'd1, 32'd1, 0, 0, 32'd1, -1, 1'b0, 1'b0, e.cycles, o);
        n_chk++; if (o.illegal !== 1'b1 || o.is_cp !== 1'b0) begin
            n_fail++; $display("FAIL illegal.flags got ill=%b is_cp=%b expected 1 0", o.illegal, o.is_cp); end
        n_chk++; if (o.req !== 0 || o.stall !== 0 || o.wb !== 0) begin
            n_fail++; $display("FAIL illegal.dispatch got req=%0d stall=%0d wb=%0d expected 0 0 0",
                o.req, o.stall, o.wb); end
    endtask

    task automatic test_rd_zero();
        obs_t o; exp_t e;
        e = model(C0, 3'd1, 5'd0, 1, 1, 32'd42, -1, 1'b0, err_m);
        run_op(C0, 3'd1, 5'd0, 32'd3, 32'd4, 1, 1, 32'd42, -1, 1'b0, 1'b0, e.cycles, o);
        err_m = e.err;
        n_chk++; if (o.wb !== 0 || o.req !== e.req || o.stall !== e.stall) begin
            n_fail++; $display("FAIL rd_zero got wb=%0d req=%0d stall=%0d expected 0 %0d %0d",
                o.wb, o.req, o.stall, e.req, e.stall); end
    endtask

    task automatic test_reset_mid_wait();
        int wbs, busy;
        @(negedge clk);
        dec_valid = 1'b1; op = C0; funct3 = 3'd3; rd = 5'd9; rs1_val = 32'hA5A5; rs2_val = 32'h5A5A;
        flush = 1'b0; cp_req_ready = 1'b1; cp_resp_valid = 1'b0;
        @(negedge clk); dec_valid = 1'b0; op = NOP;
        @(negedge clk);
        n_chk++; if (stall_d !== 1'b1 || cp_req_valid !== 1'b0 || cp_a !== 32'hA5A5) begin
            n_fail++; $display("FAIL rst_mid.pre got stall=%b req=%b a=%0h expected 1 0 a5a5",
                stall_d, cp_req_valid, cp_a); end
        #2 reset_n = 1'b0;
        #1;
        n_chk++; if ({stall_d, cp_req_valid, wb_valid, err_timeout, cp_opsel, cp_a, cp_b, wb_rd, wb_data} !== '0) begin
            n_fail++; $display("FAIL rst_mid.async got stall=%b req=%b a=%0h b=%0h rd=%0d data=%0h expected all 0",
                stall_d, cp_req_valid, cp_a, cp_b, wb_rd, wb_data); end
        cp_resp_valid = 1'b1; cp_resp_data = 32'h77;
        @(negedge clk); reset_n = 1'b1;
        wbs = 0; busy = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            if (wb_valid) wbs++;
            if (stall_d || cp_req_valid) busy++;
        end
        n_chk++; if (wbs !== 0 || busy !== 0 || wb_data !== 32'd0) begin
            n_fail++; $display("FAIL rst_mid.late_resp got wb=%0d busy=%0d data=%0h expected 0 0 0", wbs, busy, wb_data); end
        cp_resp_valid = 1'b0; cp_req_ready = 1'b0;
        err_m = 1'b0;
    endtask

    task automatic test_random();
        obs_t o; exp_t e;
        logic [6:0] opc; logic [2:0] f3; logic [4:0] rdv; logic [31:0] a, b, resp;
        int d, r, fi; bit fw;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: opc = LG;
                1: opc = LL;
                default: opc = C0;
            endcase
            f3 = 3'($urandom); rdv = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            a = $urandom; b = $urandom; resp = $urandom;
            d = $urandom_range(0, 4); r = $urandom_range(0, 10);
            fi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
            fw = 1'($urandom_range(0, 1));
            e = model(opc, f3, rdv, d, r, resp, fi, 1'b0, err_m);
            run_op(opc, f3, rdv, a, b, d, r, resp, fi, 1'b0, fw, e.cycles, o);
            err_m = e.err;
            n_chk++; if (o.is_cp !== e.legal || o.illegal !== e.illegal || o.stall !== e.stall ||
                         o.req !== e.req || o.wb !== e.wb || o.err !== e.err) begin
                n_fail++; $display("FAIL rand[%0d].ctrl got cp=%b ill=%b st=%0d req=%0d wb=%0d err=%b expected %b %b %0d %0d %0d %b",
                    i, o.is_cp, o.illegal, o.stall, o.req, o.wb, o.err,
                    e.legal, e.illegal, e.stall, e.req, e.wb, e.err); end
            if (e.req > 0) begin
                n_chk++; if (o.a !== a || o.b !== b || o.opsel !== e.opsel || o.changes !== 0 || o.req_first !== 1) begin
                    n_fail++; $display("FAIL rand[%0d].req got a=%0h b=%0h sel=%0d chg=%0d first=%0d expected %0h %0h %0d 0 1",
                        i, o.a, o.b, o.opsel, o.changes, o.req_first, a, b, e.opsel); end
            end
            if (e.wb > 0) begin
                n_chk++; if (o.data !== e.data || o.wrd !== e.wrd || o.wb_at !== e.wb_at) begin
                    n_fail++; $display("FAIL rand[%0d].wb got data=%0h rd=%0d at=%0d expected %0h %0d %0d",
                        i, o.data, o.wrd, o.wb_at, e.data, e.wrd, e.wb_at); end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; dec_valid = 1'b0; op = NOP; funct3 = 3'd0; rd = 5'd0;
        rs1_val = 32'd0; rs2_val = 32'd0; flush = 1'b0; cp_req_ready = 1'b0;
        cp_resp_valid = 1'b0; cp_resp_data = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        test_reset();
        @(negedge clk); reset_n = 1'b1;
        test_decode();
        test_basic();
        test_legacy_backpressure();
        test_timeout();
        test_flush();
        test_illegal();
        test_rd_zero();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
